calc_seq_ctrl: RTL and testbench

// Parametrised calculator core: conditions two operand-entry keys, runs entry/execute FSM, evaluates 8 ops
// at 2*DATA_W result width, drives multiplexed 7-seg display and status LEDs. Sits under the board top,

---
 rtl/calc_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: debounced two-key calculator core with 8-op ALU, chaining, error state and scanned 7-seg display
module calc_seq_ctrl #(
    parameter int DATA_W   = 4,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEB_CYC  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_number,
    input  logic [3:0]          arif,
    input  logic [1:0]          key,
    output logic [DIGITS-1:0]   anodes,
    output logic [7:0]          segments,
    output logic [2:0]          led,
    output logic [2*DATA_W-1:0] result,
    output logic                err
);
    localparam int RW = 2*DATA_W;
    localparam int DW = DIGITS*4;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int KW = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {S_A, S_B, S_RES, S_ERR} state_t;

    logic [1:0]        r_sync1, r_sync2, r_filt, r_filt_d;
    logic [KW-1:0]     r_deb [2];
    state_t            r_state, w_state_nx;
    logic [DATA_W-1:0] r_opa, r_opb, w_opa_nx, w_opb_nx, w_sw, w_a;
    logic [RW-1:0]     r_result, w_res_nx, w_val, w_ax, w_bx;
    logic              r_neg, w_neg_nx, w_eval, w_bad;
    logic [1:0]        w_ev;
    logic              w_latch, w_exec;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx, w_idx_nx;
    logic [DW-1:0]     w_disp;
    logic [3:0]        w_nib;
    logic [7:0]        w_hex, w_seg;
    logic              w_dp;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
        endcase
    endfunction

    // synchronise raw keys and accept a new level only after DEB_CYC consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_filt   <= '1;
            r_filt_d <= '1;
            r_deb[0] <= '0;
            r_deb[1] <= '0;
        end else begin
            r_sync1  <= key;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_filt[k]) r_deb[k] <= '0;
                else if (r_deb[k] == KW'(DEB_CYC - 1)) begin
                    r_filt[k] <= r_sync2[k];
                    r_deb[k]  <= '0;
                end else r_deb[k] <= r_deb[k] + 1'b1;
            end
        end
    end

    assign w_ev    = r_filt_d & ~r_filt;
    assign w_latch = w_ev[0] & ~w_ev[1];
    assign w_exec  = w_ev[1] & ~w_ev[0];
    assign w_sw    = ~in_number;
    assign w_a     = (r_state == S_RES) ? r_result[DATA_W-1:0] : r_opa;
    assign w_ax    = RW'(w_a);
    assign w_bx    = RW'(r_opb);
    assign w_bad   = arif[3] || ((arif == 4'd3 || arif == 4'd4) && r_opb == '0);

    // ALU: unsigned operands widened to the result width; divide-by-zero is caught by w_bad
    always_comb begin
        case (arif[2:0])
            3'd0: w_val = w_ax + w_bx;
            3'd1: w_val = w_ax - w_bx;
            3'd2: w_val = w_ax * w_bx;
            3'd3: w_val = (r_opb == '0) ? '0 : w_ax / w_bx;
            3'd4: w_val = (r_opb == '0) ? '0 : w_ax % w_bx;
            3'd5: w_val = w_ax & w_bx;
            3'd6: w_val = w_ax | w_bx;
            default: w_val = w_ax ^ w_bx;
        endcase
    end

    // next-state and operand/result updates driven by key events
    always_comb begin
        w_state_nx = r_state;
        w_opa_nx   = r_opa;
        w_opb_nx   = r_opb;
        w_res_nx   = r_result;
        w_neg_nx   = r_neg;
        w_eval     = 1'b0;
        unique case (r_state)
            S_A: if (w_latch) begin
                w_opa_nx   = w_sw;
                w_state_nx = S_B;
            end
            S_B: if (w_latch) w_opb_nx = w_sw;
                 else if (w_exec) w_eval = 1'b1;
            S_RES: if (w_latch) begin
                w_opa_nx   = w_sw;
                w_state_nx = S_B;
            end else if (w_exec) begin
                w_opa_nx = w_a;
                w_eval   = 1'b1;
            end
            S_ERR: if (w_latch || w_exec) begin
                w_state_nx = S_A;
                w_opa_nx   = '0;
                w_opb_nx   = '0;
                w_res_nx   = '0;
                w_neg_nx   = 1'b0;
            end
        endcase
        if (w_eval) begin
            if (w_bad) w_state_nx = S_ERR;
            else begin
                w_res_nx   = w_val;
                w_neg_nx   = (arif == 4'd1) && (w_a < r_opb);
                w_state_nx = S_RES;
            end
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_A;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_opa    <= w_opa_nx;
            r_opb    <= w_opb_nx;
            r_result <= w_res_nx;
            r_neg    <= w_neg_nx;
        end
    end

    assign led    = (r_state == S_A) ? 3'b110 : (r_state == S_B) ? 3'b101 : (r_state == S_RES) ? 3'b011 : 3'b000;
    assign err    = (r_state == S_ERR);
    assign result = r_result;

    assign w_idx_nx = (r_cnt == CW'(SCAN_DIV - 1)) ? ((r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1) : r_idx;
    assign w_disp   = (r_state == S_RES) ? DW'(r_result) : DW'(w_sw);
    assign w_nib    = w_disp[w_idx_nx*4 +: 4];
    assign w_hex    = hex7(w_nib);
    assign w_dp     = (r_state == S_RES) && r_neg && (w_idx_nx == IW'(DIGITS - 1));
    assign w_seg    = (r_state == S_ERR) ? 8'h86 : (w_dp ? (w_hex & 8'h7F) : w_hex);

    // digit scan: anode and segment pattern registered together from the upcoming digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            anodes   <= ~DIGITS'(1);
            segments <= '1;
        end else begin
            r_cnt    <= (r_cnt == CW'(SCAN_DIV - 1)) ? '0 : r_cnt + 1'b1;
            r_idx    <= w_idx_nx;
            anodes   <= ~(DIGITS'(1) << w_idx_nx);
            segments <= w_seg;
        end
    end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed vectors with hand-computed expectations for calc_seq_ctrl
module tb_calc_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_number = 4'hF;
    logic [3:0] arif = 4'd0;
    logic [1:0] key = 2'b11;
    logic [3:0] anodes;
    logic [7:0] segments;
    logic [2:0] led;
    logic [7:0] result;
    logic       err;
    int n_tests = 0;
    int n_fail  = 0;

    calc_seq_ctrl #(.DATA_W(4), .DIGITS(4), .SCAN_DIV(4), .DEB_CYC(2)) dut (
        .clk(clk), .rst(rst), .in_number(in_number), .arif(arif), .key(key),
        .anodes(anodes), .segments(segments), .led(led), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input int k, input int hold);
        key[k] = 1'b0;
        repeat (hold) @(negedge clk);
        key[k] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic seg_at(input int d, input logic [7:0] exp, input string tag);
        logic [3:0] want;
        int n;
        want = ~(4'b1 << d);
        n = 0;
        while (anodes !== want && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_anode"}, anodes, want);
        check(tag, segments, exp);
    endtask

    initial begin
        logic [3:0] walk [4];
        walk = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_led", led, 3'b110);
        check("rst_result", result, 8'h00);
        check("rst_anodes", anodes, 4'b1110);
        check("rst_err", err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            check($sformatf("walk%0d", i), anodes, walk[i]);
        end

        in_number = ~4'd3; press(0, 6);
        check("t2_led_b", led, 3'b101);
        in_number = ~4'd5; press(0, 6);
        arif = 4'd2; press(1, 6);
        check("t2_result", result, 8'h0F);
        check("t2_led", led, 3'b011);
        seg_at(0, 8'h8E, "t2_d0");
        seg_at(1, 8'hC0, "t2_d1");

        in_number = ~4'd2; press(0, 6);
        in_number = ~4'd7; press(0, 6);
        arif = 4'd1; press(1, 6);
        check("t3_sub", result, 8'hFB);
        seg_at(0, 8'h83, "t3_d0");
        seg_at(1, 8'h8E, "t3_d1");
        seg_at(3, 8'h40, "t3_d3_dp");
        arif = 4'd0; press(1, 6);
        check("t3_chain", result, 8'h12);
        check("t3_chain_led", led, 3'b011);
        seg_at(0, 8'hA4, "t3c_d0");
        seg_at(3, 8'hC0, "t3c_d3");

        in_number = ~4'd9; press(0, 6);
        in_number = ~4'd0; press(0, 6);
        arif = 4'd3; press(1, 6);
        check("t4_led", led, 3'b000);
        check("t4_err", err, 1'b1);
        check("t4_result_kept", result, 8'h12);
        for (int i = 0; i < 4; i++) seg_at(i, 8'h86, $sformatf("t4_d%0d", i));
        press(0, 6);
        check("t4_clr_led", led, 3'b110);
        check("t4_clr_result", result, 8'h00);
        check("t4_clr_err", err, 1'b0);

        key[0] = 1'b0; @(negedge clk); key[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_glitch", led, 3'b110);
        key = 2'b00; repeat (6) @(negedge clk);
        key = 2'b11; repeat (6) @(negedge clk);
        check("t5_both", led, 3'b110);
        in_number = ~4'd3; press(0, 100);
        check("t5_hold_latch", led, 3'b101);
        in_number = ~4'd4; press(0, 6);
        arif = 4'd0; press(1, 100);
        check("t5_hold_exec", result, 8'h07);
        check("t5_hold_led", led, 3'b011);

        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_led", led, 3'b110);
        check("t6_anodes", anodes, 4'b1110);
        check("t6_result", result, 8'h00);
        check("t6_err", err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
